// File: rtl/ccl_pkg.sv
// Shared types, width helpers and neighbour offsets for the BFS component labeller.
package ccl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_SEED,
    S_POP,
    S_EXPAND,
    S_WRITE,
    S_DONE
  } state_t;

  // Direction indices into the 8-neighbour table used by 4-connectivity.
  localparam logic [2:0] DIR_U = 3'd1;
  localparam logic [2:0] DIR_L = 3'd3;
  localparam logic [2:0] DIR_R = 3'd4;
  localparam logic [2:0] DIR_D = 3'd6;

  function automatic int unsigned pix_aw(input int unsigned w, input int unsigned h);
    return $clog2(w * h);
  endfunction

  function automatic int unsigned rom_aw(input int unsigned w, input int unsigned h,
                                         input int unsigned dw);
    return $clog2(w * h / dw);
  endfunction

  function automatic int unsigned qptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Row offset, two's complement, for order UL,U,UR,L,R,DL,D,DR.
  function automatic logic [1:0] drow(input logic [2:0] d);
    case (d)
      3'd0, 3'd1, 3'd2: return 2'b11;
      3'd3, 3'd4:       return 2'b00;
      default:          return 2'b01;
    endcase
  endfunction

  // Column offset, two's complement, same order.
  function automatic logic [1:0] dcol(input logic [2:0] d);
    case (d)
      3'd0, 3'd3, 3'd5: return 2'b11;
      3'd1, 3'd6:       return 2'b00;
      default:          return 2'b01;
    endcase
  endfunction

  // 8-conn walks all eight; 4-conn walks U, L, R, D only.
  function automatic logic [2:0] dir_map(input logic c8, input logic [2:0] step);
    if (c8) return step;
    case (step[1:0])
      2'd0:    return DIR_U;
      2'd1:    return DIR_L;
      2'd2:    return DIR_R;
      default: return DIR_D;
    endcase
  endfunction

endpackage

// File: rtl/ccl_fifo.sv
// Circular queue with count-based full/empty and a registered overflow pulse.
module ccl_fifo
  import ccl_pkg::*;
#(
  parameter int unsigned DEPTH = 152,
  parameter int unsigned DW    = 10,
  localparam int unsigned PW   = qptr_w(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] head_c,
  output logic          full_c,
  output logic          empty_c,
  output logic [CW-1:0] count,
  output logic          ovf
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = mem[rptr];
  assign do_push = push & ~full_c;
  assign do_pop  = pop & ~empty_c;

  // Pointers, occupancy and overflow pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf <= push & full_c;
      if (do_push) wptr <= next_ptr(wptr);
      if (do_pop)  rptr <= next_ptr(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/ccl_bfs_labeler.sv
// Loads a binary image from ROM, labels components by BFS flood fill, streams labels to SRAM.
module ccl_bfs_labeler
  import ccl_pkg::*;
#(
  parameter int unsigned IMG_W   = 32,
  parameter int unsigned IMG_H   = 32,
  parameter int unsigned ROM_DW  = 8,
  parameter int unsigned LABEL_W = 3,
  parameter int unsigned SRAM_DW = 8,
  parameter int unsigned QDEPTH  = 152,
  localparam int unsigned PIX_AW = pix_aw(IMG_W, IMG_H),
  localparam int unsigned ROM_AW = rom_aw(IMG_W, IMG_H, ROM_DW),
  localparam int unsigned CNT_W  = PIX_AW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               conn8,
  output logic [ROM_AW-1:0]  rom_a,
  input  logic [ROM_DW-1:0]  rom_q,
  output logic [PIX_AW-1:0]  sram_a,
  output logic [SRAM_DW-1:0] sram_d,
  output logic               sram_wen,
  input  logic [SRAM_DW-1:0] sram_q,
  output logic               busy,
  output logic               finish,
  output logic [CNT_W-1:0]   comp_cnt,
  output logic               label_ovf,
  output logic               q_ovf
);

  localparam int unsigned NPIX   = IMG_W * IMG_H;
  localparam int unsigned NWORDS = NPIX / ROM_DW;
  localparam int unsigned COL_W  = $clog2(IMG_W);
  localparam int unsigned ROW_W  = $clog2(IMG_H);
  localparam int unsigned MAXL   = (1 << LABEL_W) - 1;
  localparam int unsigned QCW    = $clog2(QDEPTH + 1);
  localparam logic [PIX_AW-1:0] LAST = PIX_AW'(NPIX - 1);

  state_t state, state_next;

  logic               conn8_q;
  logic [ROM_AW:0]    ld_cnt;
  logic [PIX_AW-1:0]  pix, cur_pix, widx;
  logic [2:0]         dir;
  logic [LABEL_W-1:0] cur_label;

  logic               fg  [NPIX];
  logic [LABEL_W-1:0] lbl [NPIX];

  logic               push_c, pop_c, lbl_we_c;
  logic [PIX_AW-1:0]  push_data_c, lbl_waddr_c;
  logic [LABEL_W-1:0] lbl_wdata_c, seed_label_c;
  logic [CNT_W:0]     cnt_inc_c;
  logic               seed_ovf_c, scan_hit_c, nbr_hit_c, last_dir_c;
  logic [ROM_AW-1:0]  ld_word_c;
  logic [PIX_AW-1:0]  ld_base_c, nidx_c;
  logic [2:0]         dsel_c;
  logic [1:0]         dr_c, dc_c;
  logic [ROW_W+1:0]   nrow_c;
  logic [COL_W+1:0]   ncol_c;

  logic [PIX_AW-1:0]  head_c;
  logic               full_c, empty_c, fifo_ovf;
  logic [QCW-1:0]     q_count_unused;
  logic               unused_sram_q;

  assign unused_sram_q = ^sram_q;

  ccl_fifo #(.DEPTH(QDEPTH), .DW(PIX_AW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_c),
    .pop     (pop_c),
    .wdata   (push_data_c),
    .head_c  (head_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .count   (q_count_unused),
    .ovf     (fifo_ovf)
  );

  // Seed label, neighbour address/bounds and hit detection.
  always_comb begin
    cnt_inc_c    = {1'b0, comp_cnt} + (CNT_W + 1)'(1);
    seed_ovf_c   = cnt_inc_c > (CNT_W + 1)'(MAXL);
    seed_label_c = seed_ovf_c ? LABEL_W'(MAXL) : LABEL_W'(cnt_inc_c);
    scan_hit_c   = fg[pix] && (lbl[pix] == '0);
    ld_word_c    = ROM_AW'(ld_cnt - (ROM_AW + 1)'(1));
    ld_base_c    = PIX_AW'(ld_word_c) * PIX_AW'(ROM_DW);
    dsel_c       = dir_map(conn8_q, dir);
    dr_c         = drow(dsel_c);
    dc_c         = dcol(dsel_c);
    nrow_c       = {2'b00, cur_pix[PIX_AW-1:COL_W]} + {{ROW_W{dr_c[1]}}, dr_c};
    ncol_c       = {2'b00, cur_pix[COL_W-1:0]} + {{COL_W{dc_c[1]}}, dc_c};
    nidx_c       = {nrow_c[ROW_W-1:0], ncol_c[COL_W-1:0]};
    // Bounds: top two bits clear means 0 <= coord < 2^width.
    nbr_hit_c    = ~nrow_c[ROW_W+1] & ~nrow_c[ROW_W] & ~ncol_c[COL_W+1] & ~ncol_c[COL_W]
                   & fg[nidx_c] & (lbl[nidx_c] == '0);
    last_dir_c   = conn8_q ? (dir == 3'd7) : (dir == 3'd3);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state and per-cycle label/queue strobes.
  always_comb begin
    state_next  = state;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    push_data_c = '0;
    lbl_we_c    = 1'b0;
    lbl_waddr_c = '0;
    lbl_wdata_c = '0;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_LOAD;
      S_LOAD: if (ld_cnt == (ROM_AW + 1)'(NWORDS)) state_next = S_SCAN;
      S_SCAN: begin
        if (scan_hit_c)       state_next = S_SEED;
        else if (pix == LAST) state_next = S_WRITE;
      end
      S_SEED: begin
        lbl_we_c    = 1'b1;
        lbl_waddr_c = pix;
        lbl_wdata_c = seed_label_c;
        push_c      = 1'b1;
        push_data_c = pix;
        state_next  = S_POP;
      end
      S_POP: begin
        if (empty_c) begin
          state_next = (pix == LAST) ? S_WRITE : S_SCAN;
        end else begin
          pop_c      = 1'b1;
          state_next = S_EXPAND;
        end
      end
      S_EXPAND: begin
        if (nbr_hit_c) begin
          lbl_we_c    = 1'b1;
          lbl_waddr_c = nidx_c;
          lbl_wdata_c = cur_label;
          push_c      = 1'b1;
          push_data_c = nidx_c;
        end
        if (last_dir_c) state_next = S_POP;
      end
      S_WRITE: if (widx == LAST) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_a     <= '0;
      sram_a    <= '0;
      sram_d    <= '0;
      sram_wen  <= 1'b1;
      busy      <= 1'b0;
      finish    <= 1'b0;
      comp_cnt  <= '0;
      label_ovf <= 1'b0;
      q_ovf     <= 1'b0;
      conn8_q   <= 1'b0;
      ld_cnt    <= '0;
      pix       <= '0;
      cur_pix   <= '0;
      widx      <= '0;
      dir       <= '0;
      cur_label <= '0;
    end else begin
      sram_wen <= 1'b1;
      if (fifo_ovf) q_ovf <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE) begin
            finish <= 1'b1;
            busy   <= 1'b0;
          end
          if (start) begin
            comp_cnt  <= '0;
            label_ovf <= 1'b0;
            q_ovf     <= 1'b0;
            rom_a     <= '0;
            ld_cnt    <= '0;
            pix       <= '0;
            widx      <= '0;
            conn8_q   <= conn8;
            busy      <= 1'b1;
            finish    <= 1'b0;
          end
        end
        S_LOAD: begin
          rom_a  <= rom_a + ROM_AW'(1);
          ld_cnt <= ld_cnt + (ROM_AW + 1)'(1);
        end
        S_SCAN: if (!scan_hit_c) pix <= pix + PIX_AW'(1);
        S_SEED: begin
          cur_label <= seed_label_c;
          if (comp_cnt != {CNT_W{1'b1}}) comp_cnt <= comp_cnt + CNT_W'(1);
          if (seed_ovf_c) label_ovf <= 1'b1;
        end
        S_POP: begin
          if (empty_c) begin
            pix <= pix + PIX_AW'(1);
          end else begin
            cur_pix <= head_c;
            dir     <= '0;
          end
        end
        S_EXPAND: dir <= dir + 3'd1;
        S_WRITE: begin
          sram_a   <= widx;
          sram_d   <= SRAM_DW'(lbl[widx]);
          sram_wen <= 1'b0;
          widx     <= widx + PIX_AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Foreground/label buffer: filled during LOAD, labelled during SEED/EXPAND.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NPIX; i++) begin
        fg[i]  <= 1'b0;
        lbl[i] <= '0;
      end
    end else begin
      if (state == S_LOAD && ld_cnt != '0) begin
        for (int unsigned i = 0; i < ROM_DW; i++) begin
          fg[ld_base_c + PIX_AW'(i)]  <= rom_q[ROM_DW-1-i];
          lbl[ld_base_c + PIX_AW'(i)] <= '0;
        end
      end
      if (lbl_we_c) lbl[lbl_waddr_c] <= lbl_wdata_c;
    end
  end

endmodule

// File: doc/ccl_bfs_labeler.md
Name: ccl_bfs_labeler

Overview:
- Parametrised successor to the fixed 32x32, 8-connected component labeller.
- Loads a binary image from ROM, labels connected foreground regions by breadth-first flood fill, then writes one label per pixel to an external SRAM.
- New over the previous generation:
  - image size, ROM width, label width and queue depth are parameters;
  - 4- or 8-connectivity is selectable per run;
  - neighbours are checked against image edges, so there is no row wrap-around;
  - start/busy handshake;
  - sticky label-overflow and queue-overflow flags;
  - component count output.

Parameters:
- IMG_W, 32, image width in pixels (power of 2, >=8)
- IMG_H, 32, image height in pixels (power of 2, >=2)
- ROM_DW, 8, pixels per ROM word; must divide IMG_W
- LABEL_W, 3, label width; 0 = background; max label = 2^LABEL_W-1
- SRAM_DW, 8, SRAM data width, >= LABEL_W
- QDEPTH, 152, BFS queue entries

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse in IDLE/DONE begins a run; ignored otherwise
- conn8  in  1  sampled on start: 1 = 8-connectivity, 0 = 4-connectivity
- rom_a  out  log2(IMG_W*IMG_H/ROM_DW)  ROM word address
- rom_q  in  ROM_DW  ROM data, valid one cycle after rom_a; MSB = leftmost pixel
- sram_a  out  log2(IMG_W*IMG_H)  SRAM address = row*IMG_W+col
- sram_d  out  SRAM_DW  label, zero-extended
- sram_wen  out  1  active-low write enable
- sram_q  in  SRAM_DW  unused; reserved for a readback mode
- busy  out  1  high from the cycle after start until finish rises
- finish  out  1  high in DONE; held until the next start or reset
- comp_cnt  out  log2(IMG_W*IMG_H)+1  components found, saturating
- label_ovf  out  1  sticky: more components than labels
- q_ovf  out  1  sticky: push attempted with queue full

Behaviour:
- Reset values: rom_a=0, sram_a=0, sram_d=0, sram_wen=1, busy=0, finish=0, comp_cnt=0, label_ovf=0, q_ovf=0. Internal label buffer, queue pointers and state are cleared; state = IDLE.
- Reset asserted mid-run aborts the run immediately; no further SRAM writes occur.

State machine: IDLE -> LOAD -> SCAN <-> {SEED -> EXPAND <-> POP} -> WRITE -> DONE -> (start) -> LOAD.
- IDLE/DONE, on start:
  - clear comp_cnt, flags, rom_a and pixel counter;
  - latch conn8;
  - go to LOAD.
- LOAD:
  - rom_a increments each cycle;
  - rom_q for word k is stored into buffer[k*ROM_DW .. +ROM_DW-1] the next cycle, as foreground=1 or background=0;
  - lasts IMG_W*IMG_H/ROM_DW+1 cycles.
- SCAN:
  - walks pixel index p from 0 upward, one per cycle;
  - on an unlabelled foreground pixel, goes to SEED;
  - after the last index, goes to WRITE.
- SEED (1 cycle):
  - cur_label = min(comp_cnt+1, 2^LABEL_W-1); if comp_cnt+1 exceeds max, set label_ovf;
  - buffer[p] = cur_label; push p; comp_cnt++.
- POP (1 cycle):
  - queue empty -> SCAN, resuming at p+1;
  - otherwise dequeue into cur_pix and go to EXPAND with dir=0.
- EXPAND:
  - checks one neighbour per cycle: 4 cycles in 4-conn (U, L, R, D), 8 cycles in 8-conn (UL, U, UR, L, R, DL, D, DR);
  - a neighbour outside the image (row<0, row>=IMG_H, col<0, col>=IMG_W) is skipped without any memory access;
  - an in-image neighbour that is foreground and unlabelled is set to cur_label and pushed;
  - after the last direction, go to POP.
- Queue:
  - circular, QDEPTH entries, separate read/write pointers plus count; wrap modulo QDEPTH;
  - push when full: pixel is still marked, not enqueued, q_ovf set (the component may end up partially labelled; this is accepted);
  - simultaneous push and pop cannot occur, since pop happens only in POP.
- Labelled pixels are never revisited. Internal label storage is LABEL_W bits plus one "foreground" marker per pixel.
- WRITE:
  - one pixel per cycle, index 0..IMG_W*IMG_H-1;
  - sram_a = index, sram_d = label (0 for background), sram_wen=0;
  - every address is written exactly once;
  - the cycle after the last write, sram_wen=1, finish=1, busy=0.
- start while busy is ignored.

Decomposition:
- Package ccl_pkg holds:
  - state enum;
  - direction offset constants (drow, dcol per direction);
  - derived width localparams: PIX_AW, ROM_AW, QPTR_W.
- One sub-module, ccl_fifo: parametrised circular queue (DEPTH, DW) with push/pop/full/empty/count and an overflow pulse.

Test Plan:
- All-zero 32x32 image, conn8 -> 1024 writes of 0, comp_cnt=0, no flags, finish after LOAD+SCAN+WRITE cycles.
- Pixels (r0,c0) and (r1,c1) only -> conn8: both label 1, comp_cnt=1; conn4: labels 1 and 2, comp_cnt=2.
- Pixels (r0,c31) and (r1,c0) only, conn8 -> labels 1 and 2 (no edge wrap), comp_cnt=2.
- LABEL_W=2, four isolated pixels -> labels 1, 2, 3, 3; label_ovf=1; comp_cnt=4.
- Solid 32x32 foreground with QDEPTH=4 -> q_ovf=1, finish still asserted, every address written once.
- Reset asserted during EXPAND -> all outputs return to reset values next edge; a new start then gives a correct full result.
